// File: rtl/divider_8bit_seq.sv
// divider_8bit_seq
// Sequential 8-bit unsigned restoring divider with a start/done handshake.
// One trial subtraction and one quotient bit per clock, MSB first.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   reset        - synchronous, active-high reset
//   start        - request a division (sampled only in IDLE)
//   dividend     - unsigned dividend, captured on the accepting edge
//   divisor      - unsigned divisor, captured on the accepting edge
//   busy         - high while iterating (BUSY state)
//   done         - one-cycle completion pulse (DONE state)
//   quotient     - registered result quotient
//   remainder    - registered result remainder
//   div_by_zero  - set together with done when the captured divisor was 0
module divider_8bit_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] part_rem;   // partial remainder
    logic [7:0] quo_sh;     // dividend shifting out, quotient shifting in
    logic [7:0] div_lat;    // latched divisor
    logic [2:0] cnt;

    logic [8:0] trial;
    logic [7:0] rem_nxt;
    logic [7:0] quo_nxt;

    // One restoring step. part_rem < div_lat holds between steps, so
    // {part_rem, msb} fits in 9 bits and a non-borrowing result fits in 8.
    always_comb begin
        trial = {part_rem, quo_sh[7]} - {1'b0, div_lat};
        if (!trial[8]) begin
            rem_nxt = trial[7:0];
            quo_nxt = {quo_sh[6:0], 1'b1};
        end else begin
            rem_nxt = {part_rem[6:0], quo_sh[7]};
            quo_nxt = {quo_sh[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            part_rem    <= 8'd0;
            quo_sh      <= 8'd0;
            div_lat     <= 8'd0;
            cnt         <= 3'd0;
            quotient    <= 8'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_lat  <= divisor;
                        quo_sh   <= dividend;
                        part_rem <= 8'd0;
                        cnt      <= 3'd0;
                        if (divisor == 8'd0) begin
                            quotient    <= 8'hFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    part_rem <= rem_nxt;
                    quo_sh   <= quo_nxt;
                    cnt      <= cnt + 3'd1;
                    // Results are published only on the last step so the
                    // outputs never expose a partial quotient.
                    if (cnt == 3'd7) begin
                        quotient    <= quo_nxt;
                        remainder   <= rem_nxt;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule

// File: tb/tb_divider_8bit_seq.sv
module tb_divider_8bit_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] bnd_a [5] = '{8'd10, 8'd255, 8'd3, 8'd255, 8'd0};
    logic [7:0] bnd_b [5] = '{8'd4,  8'd1,   8'd10, 8'd255, 8'd5};

    divider_8bit_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: push the expected result for a/b.
    task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Pulse start for one cycle; returns at the negedge after the accepting edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        push_exp(a, b);
        @(negedge clk);
        start = 1'b0;
        dividend = $urandom_range(0, 255);
        divisor  = $urandom_range(0, 255);
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int k, output int busy_cnt);
        k = 0; busy_cnt = 0;
        while (!done && k < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int k, bc;
        exp_t e;
        launch(8'd100, 8'd7);
        wait_done(k, bc);
        e = exp_q.pop_front();
        checks++;
        if (k !== 8 || bc !== 8) begin
            failures++;
            $display("FAIL basic_latency: got done_edge=%0d busy_cycles=%0d, want 8 8", k, bc);
        end
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b busy=%b, want q=%0d r=%0d dz=%b busy=0",
                     quotient, remainder, div_by_zero, busy, e.q, e.r, e.dz);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
                failures++;
                $display("FAIL basic_hold: got done=%b busy=%b q=%0d r=%0d, want 0 0 14 2",
                         done, busy, quotient, remainder);
            end
        end
    endtask

    task automatic test_boundary;
        int k, bc;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            launch(bnd_a[i], bnd_b[i]);
            wait_done(k, bc);
            e = exp_q.pop_front();
            checks++;
            if (k !== 8 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL boundary_%0d/%0d: got edge=%0d q=%0d r=%0d dz=%b, want edge=8 q=%0d r=%0d dz=0",
                         bnd_a[i], bnd_b[i], k, quotient, remainder, div_by_zero, e.q, e.r);
            end
        end
    endtask

    task automatic test_div_zero;
        int k, bc;
        exp_t e;
        launch(8'd5, 8'd0);
        wait_done(k, bc);
        e = exp_q.pop_front();
        checks++;
        if (k !== 0 || bc !== 0 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
            failures++;
            $display("FAIL div_zero: got edge=%0d busy_cycles=%0d q=%0d r=%0d dz=%b, want 0 0 q=%0d r=%0d dz=1",
                     k, bc, quotient, remainder, div_by_zero, e.q, e.r);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL div_zero_after: got done=%b busy=%b dz=%b, want 0 0 1", done, busy, div_by_zero);
        end
        launch(8'd9, 8'd3);
        wait_done(k, bc);
        e = exp_q.pop_front();
        checks++;
        if (k !== 8 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_zero_clear: got edge=%0d q=%0d r=%0d dz=%b, want edge=8 q=%0d r=%0d dz=0",
                     k, quotient, remainder, div_by_zero, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back;
        int k, bc;
        exp_t e;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd9;
        push_exp(8'd200, 8'd9);
        @(negedge clk);
        // Operands change mid-operation; start stays high throughout.
        dividend = 8'd17; divisor = 8'd4;
        wait_done(k, bc);
        e = exp_q.pop_front();
        checks++;
        if (k !== 8 || quotient !== e.q || remainder !== e.r) begin
            failures++;
            $display("FAIL b2b_first: got edge=%0d q=%0d r=%0d, want edge=8 q=%0d r=%0d",
                     k, quotient, remainder, e.q, e.r);
        end
        push_exp(8'd17, 8'd4);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: got busy=%b done=%b, want 0 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_reaccept: got busy=%b, want 1", busy);
        end
        start = 1'b0; dividend = 8'd1; divisor = 8'd1;
        wait_done(k, bc);
        e = exp_q.pop_front();
        checks++;
        if (k !== 8 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got edge=%0d q=%0d r=%0d, want edge=8 q=%0d r=%0d",
                     k, quotient, remainder, e.q, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int k, bc;
        int seen_done;
        exp_t e;
        launch(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", seen_done);
        end
        launch(8'd100, 8'd7);
        wait_done(k, bc);
        e = exp_q.pop_front();
        checks++;
        if (k !== 8 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_rerun: got edge=%0d q=%0d r=%0d, want edge=8 q=%0d r=%0d",
                     k, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_sweep;
        int k, bc;
        int errs;
        logic [7:0] a;
        exp_t e;
        errs = 0;
        for (int b = 1; b < 256; b++) begin
            a = $urandom_range(0, 255);
            launch(a, 8'(b));
            wait_done(k, bc);
            e = exp_q.pop_front();
            checks++;
            if (k !== 8 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
                failures++;
                errs++;
                if (errs < 10)
                    $display("FAIL sweep_%0d/%0d: got edge=%0d q=%0d r=%0d, want edge=8 q=%0d r=%0d",
                             a, b, k, quotient, remainder, e.q, e.r);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
